map_merger: RTL and testbench

//   Output-side merge stage of the conv datapath; sits directly upstream of omap_biu.

---
 rtl/map_merger.sv | 144 ++++++++++++++
 tb/tb_map_merger.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/map_merger.sv
// map_merger: output-side merge stage of the conv datapath.
// Requantizes each signed 32-bit accumulator beat to int8 using an optional ReLU,
// a round-half-up arithmetic right shift and saturation. Packs four bytes per
// 32-bit word and streams the words to omap_biu. Counts the words in each frame,
// zero-pads a short final word and pulses frame_done when a frame ends.
//
// Handshakes: a transfer happens on any rising edge where valid & ready are both 1.
// Once map_merger2omap_biu_vld is raised, it and the data stay unchanged until
// that transfer. The upstream acc_* side may present or withdraw a beat freely.
// acc_rdy is combinational from the downstream ready, so one beat per cycle is
// sustained while omap_biu keeps accepting words.
module map_merger #(
    parameter int FRAME_WORDS = 200704,
    parameter int SHIFT_W     = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               conv_start,
    input  logic               relu_en,
    input  logic [SHIFT_W-1:0] quant_shift,
    input  logic [31:0]        acc_data,
    input  logic               acc_last,
    input  logic               acc_vld,
    output logic               acc_rdy,
    output logic [31:0]        map_merger2omap_biu_data,
    output logic               map_merger2omap_biu_vld,
    input  logic               map_merger2omap_biu_rdy,
    output logic               frame_done
);

    localparam int CNT_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_WORDS - 1);

    logic [1:0]       byte_idx_q, byte_idx_d;
    logic [31:0]      pack_q, pack_d;
    logic [31:0]      data_q, data_d;
    logic             vld_q, vld_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic             frame_done_q, frame_done_d;

    logic signed [33:0] v_ext;
    logic signed [33:0] rounded;
    logic signed [33:0] shifted;
    logic [7:0]         q_byte;
    logic [31:0]        packed_word;
    logic               accept;
    logic               xfer;
    logic               word_close;

    assign acc_rdy = !conv_start && (!vld_q || map_merger2omap_biu_rdy);
    assign accept  = acc_vld && acc_rdy;
    assign xfer    = vld_q && map_merger2omap_biu_rdy;

    assign map_merger2omap_biu_data = data_q;
    assign map_merger2omap_biu_vld  = vld_q;
    assign frame_done               = frame_done_q;

    // Requantize the incoming beat: ReLU, round-half-up arithmetic shift, int8 saturation.
    always_comb begin
        v_ext   = (relu_en && acc_data[31]) ? 34'sd0 : {{2{acc_data[31]}}, acc_data};
        rounded = v_ext;
        shifted = v_ext;
        if (quant_shift != '0) begin
            rounded = v_ext + (34'sd1 <<< (quant_shift - 1'b1));
            shifted = rounded >>> quant_shift;
        end
        if (shifted > 34'sd127) begin
            q_byte = 8'h7F;
        end else if (shifted < -34'sd128) begin
            q_byte = 8'h80;
        end else begin
            q_byte = shifted[7:0];
        end
        // Higher lanes are still zero because the pack buffer is cleared after every word.
        packed_word = pack_q | ({24'd0, q_byte} << {byte_idx_q, 3'b000});
        word_close  = (byte_idx_q == 2'd3) || acc_last;
    end

    // Next-state for the packer, the output register and the frame word counter.
    always_comb begin
        byte_idx_d   = byte_idx_q;
        pack_d       = pack_q;
        data_d       = data_q;
        vld_d        = vld_q;
        last_d       = last_q;
        word_cnt_d   = word_cnt_q;
        frame_done_d = 1'b0;
        if (conv_start) begin
            byte_idx_d = 2'd0;
            pack_d     = 32'd0;
            data_d     = 32'd0;
            vld_d      = 1'b0;
            last_d     = 1'b0;
            word_cnt_d = '0;
        end else begin
            if (xfer) begin
                vld_d = 1'b0;
                if (last_q || (word_cnt_q == CNT_LAST)) begin
                    word_cnt_d   = '0;
                    frame_done_d = 1'b1;
                end else begin
                    word_cnt_d = word_cnt_q + 1'b1;
                end
            end
            // A completing beat can only be accepted when the output register is free
            // or being emptied this cycle, so the reload never overwrites a pending word.
            if (accept) begin
                if (word_close) begin
                    data_d     = packed_word;
                    vld_d      = 1'b1;
                    last_d     = acc_last;
                    byte_idx_d = 2'd0;
                    pack_d     = 32'd0;
                end else begin
                    pack_d     = packed_word;
                    byte_idx_d = byte_idx_q + 2'd1;
                end
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            byte_idx_q   <= 2'd0;
            pack_q       <= 32'd0;
            data_q       <= 32'd0;
            vld_q        <= 1'b0;
            last_q       <= 1'b0;
            word_cnt_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            byte_idx_q   <= byte_idx_d;
            pack_q       <= pack_d;
            data_q       <= data_d;
            vld_q        <= vld_d;
            last_q       <= last_d;
            word_cnt_q   <= word_cnt_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_map_merger.sv
// Bench for map_merger: directed vectors with hand-computed words, a scoreboard
// fed by a reference requantizer, a per-cycle frame_done model and a random
// backpressure run.
module tb_map_merger;

    localparam int FW = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        conv_start;
    logic        relu_en;
    logic [4:0]  quant_shift;
    logic [31:0] acc_data;
    logic        acc_last;
    logic        acc_vld;
    logic        acc_rdy;
    logic [31:0] out_data;
    logic        out_vld;
    logic        out_rdy;
    logic        frame_done;

    always #5 clk = ~clk;

    map_merger #(.FRAME_WORDS(FW), .SHIFT_W(5)) dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .conv_start               (conv_start),
        .relu_en                  (relu_en),
        .quant_shift              (quant_shift),
        .acc_data                 (acc_data),
        .acc_last                 (acc_last),
        .acc_vld                  (acc_vld),
        .acc_rdy                  (acc_rdy),
        .map_merger2omap_biu_data (out_data),
        .map_merger2omap_biu_vld  (out_vld),
        .map_merger2omap_biu_rdy  (out_rdy),
        .frame_done               (frame_done)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboard / reference model ----------------
    logic [31:0] exp_q[$];
    logic        exp_last_q[$];
    int          m_idx = 0;
    logic [31:0] m_pack = 32'd0;

    function automatic logic [7:0] quant(input logic [31:0] a, input logic relu, input int s);
        longint v;
        longint r;
        v = longint'($signed(a));
        if (relu && v < 0) v = 0;
        if (s > 0) r = (v + (longint'(1) << (s - 1))) >>> s;
        else r = v;
        if (r > 127) return 8'h7F;
        if (r < -128) return 8'h80;
        return r[7:0];
    endfunction

    task automatic model_accept(input logic [31:0] d, input logic l);
        logic [7:0] b;
        b = quant(d, relu_en, int'(quant_shift));
        m_pack = m_pack | (32'(b) << (8 * m_idx));
        if (m_idx == 3 || l) begin
            exp_q.push_back(m_pack);
            exp_last_q.push_back(l);
            m_idx  = 0;
            m_pack = 32'd0;
        end else begin
            m_idx++;
        end
    endtask

    // ---------------- output monitor ----------------
    int          mcnt = 0;
    bit          fd_pend = 0;
    bit          prev_stall = 0;
    logic [31:0] prev_data = 32'd0;
    int          words_seen = 0;
    int          fd_total = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            check("frame_done", 32'(frame_done), 32'(fd_pend));
            if (prev_stall && !conv_start) begin
                check("hold_vld", 32'(out_vld), 32'd1);
                check("hold_data", out_data, prev_data);
            end
            if (conv_start) begin
                mcnt       = 0;
                fd_pend    = 0;
                prev_stall = 0;
            end else begin
                fd_pend = 0;
                if (out_vld && out_rdy) begin
                    words_seen++;
                    check("word_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        logic [31:0] e;
                        logic        l;
                        e = exp_q.pop_front();
                        l = exp_last_q.pop_front();
                        check("word", out_data, e);
                        if (l || mcnt == FW - 1) begin
                            mcnt    = 0;
                            fd_pend = 1;
                            fd_total++;
                        end else begin
                            mcnt++;
                        end
                    end
                end
                prev_stall = out_vld && !out_rdy;
                prev_data  = out_data;
            end
        end
    end

    // ---------------- random backpressure ----------------
    bit rand_rdy = 0;
    always @(posedge clk) begin
        #1;
        if (rand_rdy) out_rdy = ($urandom_range(0, 99) < 30);
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic l);
        int n;
        n        = 0;
        acc_data = d;
        acc_last = l;
        acc_vld  = 1'b1;
        @(negedge clk);
        while (!acc_rdy && n < 2000) begin
            n++;
            @(negedge clk);
        end
        if (!acc_rdy) begin
            check("acc_rdy_timeout", 32'(acc_rdy), 32'd1);
            acc_vld = 1'b0;
        end else begin
            @(posedge clk);
            model_accept(d, l);
            #1;
            acc_vld  = 1'b0;
            acc_last = 1'b0;
        end
    endtask

    task automatic pulse_start(input bit with_beat);
        conv_start = 1'b1;
        acc_vld    = with_beat;
        acc_data   = 32'h55;
        acc_last   = 1'b0;
        @(negedge clk);
        check("start_acc_rdy", 32'(acc_rdy), 32'd0);
        @(posedge clk);
        exp_q.delete();
        exp_last_q.delete();
        m_idx  = 0;
        m_pack = 32'd0;
        #1;
        conv_start = 1'b0;
        acc_vld    = 1'b0;
        check("start_vld", 32'(out_vld), 32'd0);
        check("start_byte_idx", 32'(dut.byte_idx_q), 32'd0);
        check("start_word_cnt", 32'(dut.word_cnt_q), 32'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int w0;
        int f0;
        int n;
        rst_n       = 1'b0;
        conv_start  = 1'b0;
        relu_en     = 1'b0;
        quant_shift = 5'd0;
        acc_data    = 32'd0;
        acc_last    = 1'b0;
        acc_vld     = 1'b0;
        out_rdy     = 1'b0;

        // Reset
        repeat (3) tick();
        @(negedge clk);
        check("rst_vld", 32'(out_vld), 32'd0);
        check("rst_data", out_data, 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_acc_rdy", 32'(acc_rdy), 32'd1);
        check("rst_byte_idx", 32'(dut.byte_idx_q), 32'd0);
        tick();

        // 1: no ReLU, no shift, saturation; word held while stalled
        out_rdy = 1'b0;
        send_beat(32'd5, 1'b0);
        send_beat(32'hFFFF_FFFD, 1'b0);
        send_beat(32'd127, 1'b0);
        check("t1_vld_early", 32'(out_vld), 32'd0);
        send_beat(32'd200, 1'b0);
        check("t1_vld", 32'(out_vld), 32'd1);
        check("t1_data", out_data, 32'h7F7F_FD05);
        tick();
        tick();
        check("t1_stall_acc_rdy", 32'(acc_rdy), 32'd0);
        check("t1_stall_data", out_data, 32'h7F7F_FD05);
        out_rdy = 1'b1;
        tick();
        check("t1_vld_after", 32'(out_vld), 32'd0);

        // 2: ReLU + shift 4 with round half up
        relu_en     = 1'b1;
        quant_shift = 5'd4;
        send_beat(32'hFFFF_FF9C, 1'b0);
        send_beat(32'd24, 1'b0);
        send_beat(32'd23, 1'b0);
        send_beat(32'd8, 1'b0);
        check("t2_data", out_data, 32'h0101_0200);
        tick();

        // 4: acc_last on the 2nd beat of a word
        relu_en     = 1'b0;
        quant_shift = 5'd0;
        pulse_start(1'b0);
        send_beat(32'd1, 1'b0);
        send_beat(32'd2, 1'b0);
        send_beat(32'd3, 1'b0);
        send_beat(32'd4, 1'b0);
        check("t4_full_word", out_data, 32'h0403_0201);
        send_beat(32'h11, 1'b0);
        send_beat(32'h22, 1'b1);
        check("t4_data", out_data, 32'h0000_2211);
        check("t4_cnt_before", 32'(dut.word_cnt_q), 32'd1);
        tick();
        check("t4_frame_done", 32'(frame_done), 32'd1);
        check("t4_word_cnt", 32'(dut.word_cnt_q), 32'd0);
        tick();
        check("t4_frame_done_low", 32'(frame_done), 32'd0);

        // 6: conv_start with a pending word, then with a partial pack
        pulse_start(1'b0);
        send_beat(32'd9, 1'b0);
        send_beat(32'd8, 1'b0);
        send_beat(32'd7, 1'b0);
        send_beat(32'd6, 1'b0);
        out_rdy = 1'b0;
        check("t6_pending", 32'(out_vld), 32'd1);
        pulse_start(1'b1);
        out_rdy = 1'b1;
        send_beat(32'd1, 1'b0);
        send_beat(32'd2, 1'b0);
        check("t6_byte_idx2", 32'(dut.byte_idx_q), 32'd2);
        pulse_start(1'b0);
        check("t6_pack_clear", dut.pack_q, 32'd0);
        send_beat(32'h10, 1'b0);
        send_beat(32'h20, 1'b0);
        send_beat(32'h30, 1'b0);
        send_beat(32'h40, 1'b0);
        check("t6_clean_word", out_data, 32'h4030_2010);
        tick();

        // 5: FRAME_WORDS=4, 20 continuous beats
        pulse_start(1'b0);
        w0 = words_seen;
        f0 = fd_total;
        for (int i = 0; i < 20; i++) send_beat(32'(i * 3), 1'b0);
        repeat (3) tick();
        check("t5_words", 32'(words_seen - w0), 32'd5);
        check("t5_frames", 32'(fd_total - f0), 32'd1);
        check("t5_word_cnt", 32'(dut.word_cnt_q), 32'd1);

        // 3: random data with 30% ready duty
        pulse_start(1'b0);
        relu_en     = 1'b1;
        quant_shift = 5'd3;
        rand_rdy    = 1;
        for (int i = 0; i < 4096; i++) begin
            send_beat($urandom, ($urandom_range(0, 63) == 0));
        end
        rand_rdy = 0;
        out_rdy  = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || out_vld) && n < 100) begin
            tick();
            n++;
        end
        tick();
        check("t3_drain", 32'(exp_q.size()), 32'd0);
        check("t3_vld_idle", 32'(out_vld), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
